mario_motion: RTL and testbench

- Per-frame kinematics engine for the player character; sits directly upstream of the sprite-animation selector.
- Turns debounced button levels plus map-collision flags into screen position (pos_x, pos_y) and an airborne flag.
- airborne drives the animation selector's jump input; btn_left/btn_right are forwarded to it unchanged by the top level.
- All motion updates happen only on frame_tick, a single-cycle pulse once per video frame.

---
 rtl/mario_motion.sv | 162 ++++++++++++++++
 tb/tb_mario_motion.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mario_motion.sv
// Per-frame player kinematics: walking with clamps, a jump/fall arc and landing.
// Updates only on frame_tick. Jump presses are edge-captured between ticks.
module mario_motion #(
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 608,
  parameter int unsigned X_START   = 32,
  parameter int unsigned Y_GROUND  = 416,
  parameter int unsigned WALK_STEP = 2,
  parameter int unsigned JUMP_V0   = 12,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned VMAX_FALL = 12,
  parameter int unsigned POS_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_jump,
  input  logic             floor_hit,
  input  logic             ceil_hit,
  input  logic             wall_left,
  input  logic             wall_right,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             airborne,
  output logic [1:0]       mstate
);

  localparam int unsigned VY_W = 5;
  localparam int unsigned EW   = POS_W + 1;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  state_t            r_state;
  logic [POS_W-1:0]  r_pos_x;
  logic [POS_W-1:0]  r_pos_y;
  logic [VY_W-1:0]   r_vy;
  logic              r_airborne;
  logic              r_jump_req;
  logic              r_jump_prev;

  state_t            w_nxt_state;
  logic [POS_W-1:0]  w_nxt_x;
  logic [POS_W-1:0]  w_nxt_y;
  logic [VY_W-1:0]   w_nxt_vy;

  logic [EW-1:0]     w_x_ext;
  logic [EW-1:0]     w_y_ext;
  logic [EW-1:0]     w_x_inc;
  logic [EW-1:0]     w_y_fall;
  logic [VY_W:0]     w_vy_sum;
  logic [VY_W-1:0]   w_vy_up;
  logic [VY_W-1:0]   w_vy_dn;

  // Extended-width position math so clamps see over/underflow.
  assign w_x_ext  = {1'b0, r_pos_x};
  assign w_y_ext  = {1'b0, r_pos_y};
  assign w_x_inc  = w_x_ext + EW'(WALK_STEP);
  assign w_vy_sum = {1'b0, r_vy} + (VY_W+1)'(GRAVITY);
  assign w_vy_up  = (w_vy_sum >= (VY_W+1)'(VMAX_FALL)) ? VY_W'(VMAX_FALL) : VY_W'(w_vy_sum);
  assign w_vy_dn  = (r_vy > VY_W'(GRAVITY)) ? VY_W'(r_vy - VY_W'(GRAVITY)) : '0;
  assign w_y_fall = w_y_ext + EW'(w_vy_up);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_GROUND;
      r_pos_x     <= POS_W'(X_START);
      r_pos_y     <= POS_W'(Y_GROUND);
      r_vy        <= '0;
      r_airborne  <= 1'b0;
      r_jump_req  <= 1'b0;
      r_jump_prev <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_pos_x     <= w_nxt_x;
      r_pos_y     <= w_nxt_y;
      r_vy        <= w_nxt_vy;
      r_airborne  <= (w_nxt_state != ST_GROUND);
      r_jump_prev <= btn_jump;
      // A tick always consumes the pending request, used or not.
      if (frame_tick)
        r_jump_req <= 1'b0;
      else if (btn_jump && !r_jump_prev)
        r_jump_req <= 1'b1;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_x     = r_pos_x;
    w_nxt_y     = r_pos_y;
    w_nxt_vy    = r_vy;

    if (frame_tick) begin
      if (btn_left && !btn_right && !wall_left) begin
        if (w_x_ext < EW'(X_MIN + WALK_STEP))
          w_nxt_x = POS_W'(X_MIN);
        else
          w_nxt_x = POS_W'(w_x_ext - EW'(WALK_STEP));
      end else if (btn_right && !btn_left && !wall_right) begin
        if (w_x_inc > EW'(X_MAX))
          w_nxt_x = POS_W'(X_MAX);
        else
          w_nxt_x = POS_W'(w_x_inc);
      end

      case (r_state)
        ST_GROUND: begin
          if (r_jump_req) begin
            w_nxt_state = ST_RISE;
            w_nxt_vy    = VY_W'(JUMP_V0);
          end else if (!floor_hit && (r_pos_y < POS_W'(Y_GROUND))) begin
            w_nxt_state = ST_FALL;
            w_nxt_vy    = '0;
          end
        end
        ST_RISE: begin
          if (ceil_hit) begin
            w_nxt_state = ST_FALL;
            w_nxt_vy    = '0;
          end else begin
            if (w_y_ext < EW'(r_vy))
              w_nxt_y = '0;
            else
              w_nxt_y = POS_W'(w_y_ext - EW'(r_vy));
            w_nxt_vy = w_vy_dn;
            if (w_vy_dn == '0)
              w_nxt_state = ST_FALL;
          end
        end
        ST_FALL: begin
          if (floor_hit) begin
            w_nxt_state = ST_GROUND;
            w_nxt_vy    = '0;
          end else if (w_y_fall >= EW'(Y_GROUND)) begin
            w_nxt_state = ST_GROUND;
            w_nxt_y     = POS_W'(Y_GROUND);
            w_nxt_vy    = '0;
          end else begin
            w_nxt_y  = POS_W'(w_y_fall);
            w_nxt_vy = w_vy_up;
          end
        end
        default: begin
          w_nxt_state = ST_GROUND;
          w_nxt_vy    = '0;
        end
      endcase
    end
  end

  assign pos_x    = r_pos_x;
  assign pos_y    = r_pos_y;
  assign airborne = r_airborne;
  assign mstate   = r_state;

endmodule

// File: tb/tb_mario_motion.sv
// Self-checking bench for mario_motion: directed scenarios plus randomized
// stimulus against an integer reference model of the motion rules.
module tb_mario_motion;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, btn_left, btn_right, btn_jump;
  logic       floor_hit, ceil_hit, wall_left, wall_right;
  logic [9:0] pos_x, pos_y;
  logic       airborne;
  logic [1:0] mstate;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers).
  int mx, my, mv, mmode;
  bit mjreq, mjprev;

  always #5 clk = ~clk;

  mario_motion dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .floor_hit(floor_hit), .ceil_hit(ceil_hit),
    .wall_left(wall_left), .wall_right(wall_right),
    .pos_x(pos_x), .pos_y(pos_y), .airborne(airborne), .mstate(mstate)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 32; my = 416; mv = 0; mmode = 0; mjreq = 0; mjprev = 0;
  endtask

  task automatic model_clk(input bit t, l, r, j, fl, ce, wl, wr);
    int vn;
    if (t) begin
      if (l && !r && !wl) mx = (mx - 2 < 0) ? 0 : mx - 2;
      if (r && !l && !wr) mx = (mx + 2 > 608) ? 608 : mx + 2;
      if (mmode == 0) begin
        if (mjreq) begin mmode = 1; mv = 12; end
        else if (!fl && my < 416) begin mmode = 2; mv = 0; end
      end else if (mmode == 1) begin
        if (ce) begin mmode = 2; mv = 0; end
        else begin
          my = (my - mv < 0) ? 0 : my - mv;
          mv = mv - 1;
          if (mv == 0) mmode = 2;
        end
      end else begin
        if (fl) begin mmode = 0; mv = 0; end
        else begin
          vn = (mv + 1 > 12) ? 12 : mv + 1;
          if (my + vn >= 416) begin my = 416; mv = 0; mmode = 0; end
          else begin my = my + vn; mv = vn; end
        end
      end
      mjreq = 0;
    end else if (j && !mjprev) begin
      mjreq = 1;
    end
    mjprev = j;
  endtask

  task automatic cyc(input bit t, l, r, j, fl, ce, wl, wr);
    @(negedge clk);
    frame_tick = t; btn_left = l; btn_right = r; btn_jump = j;
    floor_hit = fl; ceil_hit = ce; wall_left = wl; wall_right = wr;
    @(posedge clk);
    model_clk(t, l, r, j, fl, ce, wl, wr);
    #1;
    check("pos_x", int'(pos_x), mx);
    check("pos_y", int'(pos_y), my);
    check("airborne", int'(airborne), (mmode != 0) ? 1 : 0);
    check("mstate", int'(mstate), mmode);
  endtask

  // Three idle cycles then a tick, inputs held constant across the frame.
  task automatic frame(input bit l, r, j, fl, ce, wl, wr);
    repeat (3) cyc(1'b0, l, r, j, fl, ce, wl, wr);
    cyc(1'b1, l, r, j, fl, ce, wl, wr);
  endtask

  task automatic wait_state(input string tag, input int st);
    int k = 0;
    while (int'(mstate) != st && k < 40) begin
      frame(0, 0, 0, 0, 0, 0, 0);
      k++;
    end
    check(tag, int'(mstate), st);
  endtask

  initial begin
    int air_ticks, min_y, y0;
    int exp_l[5];
    bit l, r, j;

    exp_l = '{2, 0, 0, 0, 0};
    rst = 1'b1;
    frame_tick = 0; btn_left = 0; btn_right = 0; btn_jump = 0;
    floor_hit = 0; ceil_hit = 0; wall_left = 0; wall_right = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", int'(pos_x), 32);
    check("rst_y", int'(pos_y), 416);
    check("rst_air", int'(airborne), 0);
    check("rst_state", int'(mstate), 0);
    @(negedge clk);
    rst = 1'b0;

    repeat (5) frame(0, 0, 0, 0, 0, 0, 0);
    check("idle_x", int'(pos_x), 32);
    check("idle_y", int'(pos_y), 416);

    repeat (10) frame(0, 1, 0, 0, 0, 0, 0);
    check("walk_right", int'(pos_x), 52);
    repeat (3) frame(1, 1, 0, 0, 0, 0, 0);
    check("both_hold", int'(pos_x), 52);

    // Full jump with the button held throughout: exactly one arc.
    air_ticks = 0; min_y = 416;
    repeat (30) begin
      frame(0, 0, 1, 0, 0, 0, 0);
      if (airborne) air_ticks++;
      if (int'(pos_y) < min_y) min_y = int'(pos_y);
    end
    check("air_ticks", air_ticks, 24);
    check("apex_y", min_y, 338);
    check("land_y", int'(pos_y), 416);
    check("land_state", int'(mstate), 0);

    repeat (24) frame(1, 0, 0, 0, 0, 0, 0);
    check("left_to_4", int'(pos_x), 4);
    for (int i = 0; i < 5; i++) begin
      frame(1, 0, 0, 0, 0, 0, 0);
      check("left_clamp", int'(pos_x), exp_l[i]);
    end
    repeat (3) frame(0, 1, 0, 0, 0, 0, 1);
    check("wall_right", int'(pos_x), 0);

    // Ceiling bump after three rising ticks.
    frame(0, 0, 1, 0, 0, 0, 0);
    repeat (3) frame(0, 0, 0, 0, 0, 0, 0);
    check("pre_ceil_y", int'(pos_y), 383);
    frame(0, 0, 0, 0, 1, 0, 0);
    check("ceil_state", int'(mstate), 2);
    check("ceil_y", int'(pos_y), 383);
    frame(0, 0, 0, 0, 0, 0, 0);
    check("ceil_desc", int'(pos_y), 384);
    wait_state("ceil_land", 0);

    // Asynchronous reset in the middle of a rise, mid-cycle.
    frame(0, 1, 1, 0, 0, 0, 0);
    repeat (4) frame(0, 0, 0, 0, 0, 0, 0);
    check("pre_rst_state", int'(mstate), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_x", int'(pos_x), 32);
    check("arst_y", int'(pos_y), 416);
    check("arst_air", int'(airborne), 0);
    check("arst_state", int'(mstate), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Jump edge during fall is discarded at the next tick.
    frame(0, 0, 1, 0, 0, 0, 0);
    wait_state("reach_fall", 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    wait_state("fall_land", 0);
    repeat (3) frame(0, 0, 0, 0, 0, 0, 0);
    check("no_rejump", int'(mstate), 0);

    // Randomized stimulus with persistent walking runs.
    l = 0; r = 0; j = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) begin
        l = ($urandom_range(2) == 0);
        r = ($urandom_range(2) == 0);
      end
      if ($urandom_range(5) == 0) j = ~j;
      cyc(($urandom_range(3) == 0), l, r, j,
          ($urandom_range(19) == 0), ($urandom_range(31) == 0),
          ($urandom_range(7) == 0), ($urandom_range(7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
